// File: rtl/spi_host_xact_arbiter_pkg.sv
// spi_host_xact_arbiter shared types: segment command, enums, FSM states.
// Encodings match the SPI host command queue.
package spi_host_arb_pkg;

   localparam int NumReqMax = 8;
   localparam int CsWDef    = 1;
   localparam int LenWDef   = 9;

   typedef enum logic [1:0] {
      Standard = 2'd0,
      Dual     = 2'd1,
      Quad     = 2'd2
   } speed_e;

   typedef enum logic [1:0] {
      Dummy  = 2'd0,
      RdOnly = 2'd1,
      WrOnly = 2'd2,
      Bidir  = 2'd3
   } dir_e;

   typedef struct packed {
      logic [CsWDef-1:0]  csid;
      logic [LenWDef-1:0] len;
      speed_e             speed;
      dir_e               dir;
      logic               csaat;
   } seg_cmd_t;

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StCmd  = 2'd1;
   localparam logic [1:0] StData = 2'd2;

   function automatic logic dir_has_tx(dir_e d);
      return (d == WrOnly) || (d == Bidir);
   endfunction

   function automatic logic dir_has_rx(dir_e d);
      return (d == RdOnly) || (d == Bidir);
   endfunction

endpackage

// File: rtl/spi_host_xact_arbiter_if.sv
// Requester-side and host-side streams of the SPI host arbiter.
// slave: the arbiter's view; master: the surrounding agents.
interface spi_host_xact_arbiter_if #(
   parameter int NumReq = 2
);
   import spi_host_arb_pkg::*;

   logic     [NumReq-1:0]       req_cmd_valid_i;
   seg_cmd_t [NumReq-1:0]       req_cmd_i;
   logic     [NumReq-1:0]       req_cmd_ready_o;
   logic     [NumReq-1:0][31:0] req_tx_data_i;
   logic     [NumReq-1:0]       req_tx_valid_i;
   logic     [NumReq-1:0]       req_tx_ready_o;
   logic     [31:0]             req_rx_data_o;
   logic     [NumReq-1:0]       req_rx_valid_o;
   logic     [NumReq-1:0]       req_rx_ready_i;
   seg_cmd_t                    host_cmd_o;
   logic                        host_cmd_valid_o;
   logic                        host_cmd_ready_i;
   logic     [31:0]             host_tx_data_o;
   logic                        host_tx_valid_o;
   logic                        host_tx_ready_i;
   logic     [31:0]             host_rx_data_i;
   logic                        host_rx_valid_i;
   logic                        host_rx_ready_o;

   modport slave (
      input  req_cmd_valid_i, req_cmd_i,
      output req_cmd_ready_o,
      input  req_tx_data_i, req_tx_valid_i,
      output req_tx_ready_o,
      output req_rx_data_o, req_rx_valid_o,
      input  req_rx_ready_i,
      output host_cmd_o, host_cmd_valid_o,
      input  host_cmd_ready_i,
      output host_tx_data_o, host_tx_valid_o,
      input  host_tx_ready_i,
      input  host_rx_data_i, host_rx_valid_i,
      output host_rx_ready_o
   );

   modport master (
      output req_cmd_valid_i, req_cmd_i,
      input  req_cmd_ready_o,
      output req_tx_data_i, req_tx_valid_i,
      input  req_tx_ready_o,
      input  req_rx_data_o, req_rx_valid_o,
      output req_rx_ready_i,
      input  host_cmd_o, host_cmd_valid_o,
      output host_cmd_ready_i,
      input  host_tx_data_o, host_tx_valid_o,
      output host_tx_ready_i,
      output host_rx_data_i, host_rx_valid_i,
      input  host_rx_ready_o
   );

endinterface

// File: rtl/spi_host_xact_arbiter_rr.sv
// Combinational round-robin one-hot picker.
// Search starts at ptr_i and wraps; the pointer lives in the parent.
module spi_host_arb_rr #(
   parameter  int NumReq = 2,
   localparam int PtrW   = $clog2(NumReq)
) (
   input  logic [NumReq-1:0] req_i,
   input  logic [PtrW-1:0]   ptr_i,
   output logic [NumReq-1:0] gnt_o
);

   logic found;
   int   idx;

   // first requester at or after the pointer wins
   always_comb begin
      gnt_o = '0;
      found = 1'b0;
      idx   = 0;
      for (int i = 0; i < NumReq; i++) begin
         idx = (int'(ptr_i) + i) % NumReq;
         if (!found && req_i[idx]) begin
            gnt_o[idx] = 1'b1;
            found      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/spi_host_xact_arbiter.sv
// Round-robin SPI host sharing with chip-select lock per transaction.
// Optional lock-hold timeout: define SPI_HOST_ARB_TIMEOUT_EN.
module spi_host_xact_arbiter
   import spi_host_arb_pkg::*;
#(
   parameter int NumReq        = 2,
   parameter int LenW          = LenWDef,
   parameter int CsW           = CsWDef,
   parameter int TimeoutCycles = 1024
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   spi_host_xact_arbiter_if.slave bus,
   output logic [NumReq-1:0]      grant_o,
   output logic                   timeout_o
);

   localparam int PtrW = $clog2(NumReq);
   localparam int CntW = LenW - 1;
   // seg_cmd_t is fixed-width, so a mismatched build never grants
   localparam bit CfgOk = (CsW == CsWDef) && (LenW == LenWDef) &&
                          (TimeoutCycles > 0);

   logic [1:0]        state_q, state_d;
   logic [NumReq-1:0] grant_q, grant_d;
   logic [PtrW-1:0]   ptr_q, ptr_d;
   logic [CntW-1:0]   tx_q, tx_d;
   logic [CntW-1:0]   rx_q, rx_d;
   logic              csaat_q, csaat_d;

   logic [NumReq-1:0] pick;
   logic [PtrW-1:0]   own;
   logic [PtrW-1:0]   nxt_ptr;
   logic [CntW-1:0]   words;
   seg_cmd_t          own_cmd;
   logic              own_cmd_v;
   logic              own_tx_v;
   logic [31:0]       own_tx_d;
   logic              own_rx_r;
   logic              in_cmd, in_data;
   logic              tx_act, rx_act;
   logic              cmd_hs, tx_hs, rx_hs;
   logic              expire;

   spi_host_arb_rr #(
      .NumReq(NumReq)
   ) u_rr (
      .req_i (bus.req_cmd_valid_i),
      .ptr_i (ptr_q),
      .gnt_o (pick)
   );

   // owner index from the one-hot grant
   always_comb begin
      own = '0;
      for (int i = 0; i < NumReq; i++) begin
         if (grant_q[i]) own = PtrW'(i);
      end
   end

   assign nxt_ptr = (own == PtrW'(NumReq - 1)) ? '0
                                               : own + PtrW'(1);

   assign own_cmd   = bus.req_cmd_i[own];
   assign own_cmd_v = bus.req_cmd_valid_i[own];
   assign own_tx_v  = bus.req_tx_valid_i[own];
   assign own_tx_d  = bus.req_tx_data_i[own];
   assign own_rx_r  = bus.req_rx_ready_i[own];

   assign words = CntW'(own_cmd.len[LenW-1:2]) + CntW'(1);

   assign in_cmd  = (state_q == StCmd);
   assign in_data = (state_q == StData);
   assign tx_act  = in_data && (tx_q != '0);
   assign rx_act  = in_data && (rx_q != '0);

   assign cmd_hs = in_cmd && own_cmd_v && bus.host_cmd_ready_i;
   assign tx_hs  = tx_act && own_tx_v && bus.host_tx_ready_i;
   assign rx_hs  = rx_act && bus.host_rx_valid_i && own_rx_r;

   assign bus.host_cmd_valid_o = in_cmd && own_cmd_v;
   assign bus.host_cmd_o       = in_cmd ? own_cmd : '0;
   assign bus.req_cmd_ready_o  =
      (in_cmd && bus.host_cmd_ready_i) ? grant_q : '0;

   assign bus.host_tx_valid_o = tx_act && own_tx_v;
   assign bus.host_tx_data_o  = tx_act ? own_tx_d : '0;
   assign bus.req_tx_ready_o  =
      (tx_act && bus.host_tx_ready_i) ? grant_q : '0;

   assign bus.req_rx_valid_o  =
      (rx_act && bus.host_rx_valid_i) ? grant_q : '0;
   assign bus.req_rx_data_o   = rx_act ? bus.host_rx_data_i : '0;
   assign bus.host_rx_ready_o = rx_act && own_rx_r;

   assign grant_o = grant_q;

`ifdef SPI_HOST_ARB_TIMEOUT_EN
   localparam int TmoW = $clog2(TimeoutCycles + 1);

   logic [TmoW-1:0] tmo_cnt_q, tmo_cnt_d;
   logic            tmo_q;
   logic            any_hs;
   logic            stall;

   assign any_hs = cmd_hs || tx_hs || rx_hs;
   assign stall  =
      (in_cmd && csaat_q && !own_cmd_v) ||
      (in_data && (((tx_q != '0) && !own_tx_v) ||
                   ((rx_q != '0) && !own_rx_r)));
   assign expire = stall && !any_hs &&
                   (tmo_cnt_q == TmoW'(TimeoutCycles - 1));

   // count consecutive owner-side stall cycles
   always_comb begin
      tmo_cnt_d = tmo_cnt_q;
      if (state_q == StIdle || any_hs || expire)
         tmo_cnt_d = '0;
      else if (stall)
         tmo_cnt_d = tmo_cnt_q + TmoW'(1);
   end

   // stall counter and one-cycle release pulse
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         tmo_cnt_q <= '0;
         tmo_q     <= 1'b0;
      end else begin
         tmo_cnt_q <= tmo_cnt_d;
         tmo_q     <= expire;
      end
   end

   assign timeout_o = tmo_q;
`else
   assign expire    = 1'b0;
   assign timeout_o = 1'b0;
`endif

   // arbitration, segment bookkeeping and lock release
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      ptr_d   = ptr_q;
      tx_d    = tx_q;
      rx_d    = rx_q;
      csaat_d = csaat_q;
      unique case (state_q)
         StIdle: begin
            if (CfgOk && (|bus.req_cmd_valid_i)) begin
               grant_d = pick;
               state_d = StCmd;
            end
         end
         StCmd: begin
            if (cmd_hs) begin
               tx_d    = dir_has_tx(own_cmd.dir) ? words : '0;
               rx_d    = dir_has_rx(own_cmd.dir) ? words : '0;
               csaat_d = own_cmd.csaat;
               state_d = StData;
            end
         end
         StData: begin
            if (tx_q == '0 && rx_q == '0) begin
               if (csaat_q) begin
                  state_d = StCmd;
               end else begin
                  state_d = StIdle;
                  grant_d = '0;
                  ptr_d   = nxt_ptr;
                  csaat_d = 1'b0;
               end
            end else begin
               if (tx_hs) tx_d = tx_q - CntW'(1);
               if (rx_hs) rx_d = rx_q - CntW'(1);
            end
         end
         default: begin
            state_d = StIdle;
            grant_d = '0;
         end
      endcase
      if (expire) begin
         state_d = StIdle;
         grant_d = '0;
         ptr_d   = nxt_ptr;
         csaat_d = 1'b0;
         tx_d    = '0;
         rx_d    = '0;
      end
   end

   // state registers
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= StIdle;
         grant_q <= '0;
         ptr_q   <= '0;
         tx_q    <= '0;
         rx_q    <= '0;
         csaat_q <= 1'b0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         ptr_q   <= ptr_d;
         tx_q    <= tx_d;
         rx_q    <= rx_d;
         csaat_q <= csaat_d;
      end
   end

endmodule

// File: tb/tb_spi_host_xact_arbiter.sv
// Bench for spi_host_xact_arbiter: directed and random transactions.
// Word counts and grant order come from a transaction-level model.
module tb_spi_host_xact_arbiter;
   import spi_host_arb_pkg::*;

   localparam int N = 2;

   logic         clk = 1'b0;
   logic         rst;
   logic [N-1:0] grant;
   logic         tmo;

   always #5 clk = ~clk;

   spi_host_xact_arbiter_if #(.NumReq(N)) b ();

   spi_host_xact_arbiter #(
      .NumReq        (N),
      .LenW          (9),
      .CsW           (1),
      .TimeoutCycles (16)
   ) dut (
      .clk_i     (clk),
      .rst_i     (rst),
      .bus       (b),
      .grant_o   (grant),
      .timeout_o (tmo)
   );

   int           n_run  = 0;
   int           n_fail = 0;
   int           ptr_m  = 0;
   logic [N-1:0] hold_mask = '0;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_run++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] oh(input int r);
      return 64'd1 << r;
   endfunction

   function automatic int pick_m(input logic [N-1:0] m);
      for (int k = 0; k < N; k++) begin
         if (m[(ptr_m + k) % N]) return (ptr_m + k) % N;
      end
      return -1;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clr_inputs();
      b.req_cmd_valid_i  = '0;
      b.req_cmd_i        = '0;
      b.req_tx_data_i    = '0;
      b.req_tx_valid_i   = '0;
      b.req_rx_ready_i   = '0;
      b.host_cmd_ready_i = 1'b0;
      b.host_tx_ready_i  = 1'b0;
      b.host_rx_data_i   = '0;
      b.host_rx_valid_i  = 1'b0;
   endtask

   task automatic seg(input int r, input dir_e dir,
                      input logic [8:0] len, input logic cs,
                      input bit first, input bit eager,
                      output int cyc);
      seg_cmd_t    c;
      int          etx, erx, ntx, nrx, nst;
      bit          ta, ra, txv, htr, hrv, rxr;
      logic [31:0] td, rd;
      c.csid  = 1'($urandom);
      c.len   = len;
      c.speed = speed_e'($urandom_range(0, 2));
      c.dir   = dir;
      c.csaat = cs;
      b.req_cmd_i[r]       = c;
      b.req_cmd_valid_i[r] = 1'b1;
      #1;
      if (first) begin
         chk("idle_grant", 64'(grant), 64'd0);
         tick();
      end
      chk("cmd_grant", 64'(grant), oh(r));
      chk("cmd_valid", 64'(b.host_cmd_valid_o), 64'd1);
      chk("cmd_word", 64'(b.host_cmd_o), 64'(c));
      nst = eager ? 0 : $urandom_range(0, 2);
      for (int k = 0; k < nst; k++) begin
         b.host_cmd_ready_i = 1'b0;
         #1;
         chk("cmd_rdy_stall", 64'(b.req_cmd_ready_o), 64'd0);
         tick();
      end
      b.host_cmd_ready_i = 1'b1;
      #1;
      chk("cmd_rdy", 64'(b.req_cmd_ready_o), oh(r));
      tick();
      b.host_cmd_ready_i   = 1'b0;
      b.req_cmd_valid_i[r] = hold_mask[r];
      etx = dir[1] ? int'(len >> 2) + 1 : 0;
      erx = dir[0] ? int'(len >> 2) + 1 : 0;
      ntx = 0;
      nrx = 0;
      cyc = 0;
      while ((ntx < etx || nrx < erx) && cyc < 1000) begin
         ta  = ntx < etx;
         ra  = nrx < erx;
         txv = eager || ($urandom_range(0, 3) != 0);
         htr = eager || ($urandom_range(0, 3) != 0);
         hrv = eager || ($urandom_range(0, 3) != 0);
         rxr = eager || ($urandom_range(0, 3) != 0);
         td  = $urandom;
         rd  = $urandom;
         b.req_tx_valid_i[r] = txv;
         b.req_tx_data_i[r]  = td;
         b.host_tx_ready_i   = htr;
         b.host_rx_valid_i   = hrv;
         b.host_rx_data_i    = rd;
         b.req_rx_ready_i[r] = rxr;
         for (int k = 0; k < N; k++) begin
            if (k != r) begin
               b.req_tx_valid_i[k] = 1'($urandom);
               b.req_rx_ready_i[k] = 1'($urandom);
            end
         end
         #1;
         chk("data_grant", 64'(grant), oh(r));
         chk("tx_valid", 64'(b.host_tx_valid_o), 64'(ta && txv));
         chk("tx_ready", 64'(b.req_tx_ready_o),
             (ta && htr) ? oh(r) : 64'd0);
         chk("rx_valid", 64'(b.req_rx_valid_o),
             (ra && hrv) ? oh(r) : 64'd0);
         chk("rx_ready", 64'(b.host_rx_ready_o), 64'(ra && rxr));
         if (ta) chk("tx_data", 64'(b.host_tx_data_o), 64'(td));
         if (ra) chk("rx_data", 64'(b.req_rx_data_o), 64'(rd));
`ifndef SPI_HOST_ARB_TIMEOUT_EN
         chk("no_timeout", 64'(tmo), 64'd0);
`endif
         if (ta && txv && htr) ntx++;
         if (ra && hrv && rxr) nrx++;
         cyc++;
         tick();
      end
      chk("seg_bound", 64'(cyc < 1000), 64'd1);
      b.req_tx_valid_i[r] = 1'b1;
      b.host_tx_ready_i   = 1'b1;
      b.host_rx_valid_i   = 1'b1;
      b.req_rx_ready_i[r] = 1'b1;
      #1;
      chk("exit_grant", 64'(grant), oh(r));
      chk("exit_tx_valid", 64'(b.host_tx_valid_o), 64'd0);
      chk("exit_tx_ready", 64'(b.req_tx_ready_o), 64'd0);
      chk("exit_rx_valid", 64'(b.req_rx_valid_o), 64'd0);
      chk("exit_rx_ready", 64'(b.host_rx_ready_o), 64'd0);
      tick();
      b.req_tx_valid_i  = '0;
      b.req_rx_ready_i  = '0;
      b.host_tx_ready_i = 1'b0;
      b.host_rx_valid_i = 1'b0;
      if (!cs) begin
         #1;
         chk("rel_grant", 64'(grant), 64'd0);
         ptr_m = (r + 1) % N;
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int          r, cyc, nseg;
      logic [N-1:0] mask;
      seg_cmd_t    c0;
      rst = 1'b1;
      clr_inputs();
      b.req_cmd_valid_i  = '1;
      b.host_cmd_ready_i = 1'b1;
      b.host_rx_valid_i  = 1'b1;
      b.req_rx_ready_i   = '1;
      repeat (3) tick();
      chk("rst_grant", 64'(grant), 64'd0);
      chk("rst_timeout", 64'(tmo), 64'd0);
      chk("rst_cmd_valid", 64'(b.host_cmd_valid_o), 64'd0);
      chk("rst_cmd_ready", 64'(b.req_cmd_ready_o), 64'd0);
      chk("rst_rx_ready", 64'(b.host_rx_ready_o), 64'd0);
      chk("rst_rx_valid", 64'(b.req_rx_valid_o), 64'd0);
      rst = 1'b0;
      clr_inputs();
      tick();

      // single requester, WrOnly len=7 -> 2 words
      hold_mask = '0;
      seg(0, WrOnly, 9'd7, 1'b0, 1'b1, 1'b0, cyc);

      // pointer moved to 1: dummy segment from req1 wins
      hold_mask = 2'b01;
      b.req_cmd_valid_i = 2'b11;
      r = pick_m(2'b11);
      seg(r, Dummy, 9'($urandom_range(0, 511)), 1'b0, 1'b1,
          1'b0, cyc);
      chk("dummy_cycles", 64'(cyc), 64'd0);

      // lock hold across csaat chain while req1 waits
      hold_mask = 2'b10;
      b.req_cmd_i[1] = seg_cmd_t'($urandom);
      b.req_cmd_valid_i = 2'b11;
      r = pick_m(2'b11);
      seg(r, WrOnly, 9'd3, 1'b1, 1'b1, 1'b0, cyc);
      seg(r, RdOnly, 9'd4, 1'b0, 1'b0, 1'b0, cyc);

      // fairness with both requesting
      hold_mask = 2'b11;
      for (int t = 0; t < 4; t++) begin
         b.req_cmd_valid_i = 2'b11;
         r = pick_m(2'b11);
         seg(r, dir_e'($urandom_range(0, 3)),
             9'($urandom_range(0, 15)), 1'b0, 1'b1, 1'b0, cyc);
      end

      // bidir len=11, everything ready: 3 words each in 3 cycles
      hold_mask = '0;
      b.req_cmd_valid_i = '0;
      r = pick_m(2'b01);
      seg(r, Bidir, 9'd11, 1'b0, 1'b1, 1'b1, cyc);
      chk("bidir_cycles", 64'(cyc), 64'd3);

      // maximum length: 128 words
      r = pick_m(2'b10);
      seg(r, WrOnly, 9'd511, 1'b0, 1'b1, 1'b1, cyc);
      chk("maxlen_cycles", 64'(cyc), 64'd128);

      // reset in DATA with two TX words left
      clr_inputs();
      c0 = '0;
      c0.len = 9'd11;
      c0.dir = WrOnly;
      b.req_cmd_i[0] = c0;
      b.req_cmd_valid_i[0] = 1'b1;
      tick();
      b.host_cmd_ready_i = 1'b1;
      #1;
      chk("pre_rst_cmd", 64'(b.host_cmd_valid_o), 64'd1);
      tick();
      b.host_cmd_ready_i = 1'b0;
      b.req_cmd_valid_i  = '0;
      b.req_tx_valid_i[0] = 1'b1;
      b.req_tx_data_i[0]  = 32'hA5A5_0001;
      b.host_tx_ready_i   = 1'b1;
      #1;
      chk("pre_rst_tx", 64'(b.host_tx_valid_o), 64'd1);
      tick();
      rst = 1'b1;
      b.req_cmd_valid_i  = '1;
      b.host_cmd_ready_i = 1'b1;
      b.host_rx_valid_i  = 1'b1;
      b.req_rx_ready_i   = '1;
      tick();
      chk("mid_rst_grant", 64'(grant), 64'd0);
      chk("mid_rst_tx_valid", 64'(b.host_tx_valid_o), 64'd0);
      chk("mid_rst_tx_data", 64'(b.host_tx_data_o), 64'd0);
      chk("mid_rst_tx_ready", 64'(b.req_tx_ready_o), 64'd0);
      chk("mid_rst_cmd_valid", 64'(b.host_cmd_valid_o), 64'd0);
      chk("mid_rst_cmd", 64'(b.host_cmd_o), 64'd0);
      chk("mid_rst_rx_ready", 64'(b.host_rx_ready_o), 64'd0);
      chk("mid_rst_timeout", 64'(tmo), 64'd0);
      rst = 1'b0;
      clr_inputs();
      ptr_m = 0;
      hold_mask = 2'b11;
      b.req_cmd_valid_i = 2'b11;
      r = pick_m(2'b11);
      seg(r, RdOnly, 9'd5, 1'b0, 1'b1, 1'b0, cyc);

      // random multi-segment transactions
      for (int t = 0; t < 20; t++) begin
         mask = N'($urandom_range(1, 3));
         hold_mask = mask;
         b.req_cmd_valid_i = mask;
         for (int k = 0; k < N; k++) begin
            if (!mask[k]) b.req_cmd_i[k] = seg_cmd_t'($urandom);
         end
         r = pick_m(mask);
         nseg = $urandom_range(1, 3);
         for (int s = 0; s < nseg; s++) begin
            seg(r, dir_e'($urandom_range(0, 3)),
                9'($urandom_range(0, 40)), 1'(s < nseg - 1),
                1'(s == 0), 1'b0, cyc);
         end
      end

`ifdef SPI_HOST_ARB_TIMEOUT_EN
      // locked owner goes silent: forced release after 16 cycles
      clr_inputs();
      hold_mask = '0;
      r = pick_m(2'b01);
      seg(r, WrOnly, 9'd3, 1'b1, 1'b1, 1'b1, cyc);
      b.req_cmd_valid_i[r] = 1'b0;
      b.req_cmd_valid_i[(r + 1) % N] = 1'b1;
      cyc = 0;
      while (!tmo && cyc < 40) begin
         tick();
         cyc++;
      end
      chk("tmo_cycles", 64'(cyc), 64'd16);
      chk("tmo_grant", 64'(grant), 64'd0);
      tick();
      chk("tmo_pulse", 64'(tmo), 64'd0);
      chk("tmo_next", 64'(grant), oh((r + 1) % N));
`endif

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
